// File: rtl/freqgen_pkg.sv
// freqgen_pkg: shared state type and constants for the square-wave generator.
package freqgen_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int MIN_PERIOD = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/freqgen_if.sv
// freqgen_if: run enable, period/duty load handshake and waveform outputs of freqgen.
interface freqgen_if import freqgen_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             en;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] duty_in;
    logic             out;
    logic             rise;
    logic [WIDTH-1:0] period_out;
    logic             nosignal;
    modport master (
        output en, load_valid, period_in, duty_in,
        input  load_ready, out, rise, period_out, nosignal
    );
    modport slave (
        input  en, load_valid, period_in, duty_in,
        output load_ready, out, rise, period_out, nosignal
    );
endinterface

// File: rtl/freqgen.sv
// freqgen: programmable square-wave generator with a double-buffered period/duty
// that is applied only on a period boundary.
module freqgen import freqgen_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    freqgen_if.slave io_if
);
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_p, r_d, r_pp, r_dp, r_cnt, r_pout;
    logic [WIDTH-1:0] w_p_n, w_d_n, w_cnt_n, w_dp_in;
    logic             r_pv, r_out, r_rise, r_nosig;
    logic             w_take, w_acc, w_bnd, w_run_n;

    assign w_acc   = io_if.load_valid & ~r_pv;
    assign w_bnd   = r_cnt == r_p - ONE;
    assign w_run_n = w_state_n != IDLE;
    assign w_dp_in = (io_if.period_in >= MIN_P && io_if.duty_in >= io_if.period_in) ?
                     io_if.period_in - ONE : io_if.duty_in;

    // RUN and DRAIN count identically; en only matters at the boundary
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_p_n     = r_p;
        w_d_n     = r_d;
        w_take    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pv && r_pp < MIN_P) begin
                    w_take = 1'b1;
                end else if (r_pv && io_if.en) begin
                    w_take    = 1'b1;
                    w_state_n = RUN;
                    w_p_n     = r_pp;
                    w_d_n     = r_dp;
                    w_cnt_n   = '0;
                end
            end
            default: begin
                if (!w_bnd) begin
                    w_cnt_n   = r_cnt + ONE;
                    w_state_n = io_if.en ? RUN : DRAIN;
                end else if (!io_if.en) begin
                    w_cnt_n   = '0;
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n   = '0;
                    w_state_n = RUN;
                    if (r_pv) begin
                        w_take    = 1'b1;
                        w_state_n = r_pp < MIN_P ? IDLE : RUN;
                        w_p_n     = r_pp < MIN_P ? r_p : r_pp;
                        w_d_n     = r_pp < MIN_P ? r_d : r_dp;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_d     <= '0;
            r_pp    <= '0;
            r_dp    <= '0;
            r_cnt   <= '0;
            r_pv    <= 1'b0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_pout  <= '0;
            r_nosig <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_p     <= w_p_n;
            r_d     <= w_d_n;
            r_cnt   <= w_cnt_n;
            r_pv    <= (r_pv & ~w_take) | w_acc;
            r_pp    <= w_acc ? io_if.period_in : r_pp;
            r_dp    <= w_acc ? w_dp_in : r_dp;
            r_out   <= w_run_n && w_cnt_n < w_d_n;
            r_rise  <= w_run_n && w_cnt_n == '0 && w_d_n != '0;
            r_pout  <= w_run_n ? w_p_n : '0;
            r_nosig <= !w_run_n;
        end
    end

    assign io_if.load_ready = ~r_pv;
    assign io_if.out        = r_out;
    assign io_if.rise       = r_rise;
    assign io_if.period_out = r_pout;
    assign io_if.nosignal   = r_nosig;
endmodule

// File: doc/freqgen.md
# freqgen

Programmable square-wave generator: the transmit-side counterpart to the team's period-measuring frequency counter. Software or upstream logic loads a period and high-time in clock cycles through a valid/ready handshake. The block produces a glitch-free registered output whose rising edges are exactly `period` clocks apart, plus a one-cycle rise strobe. Parameter updates are double-buffered and take effect only on a period boundary.

## Interface
- `WIDTH`, default 16: width of the period, duty and counter values.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; deassertion stops the output at the end of the current period.
- `load_valid`  in  1  new period/duty offered.
- `load_ready`  out  1  pending slot empty; a transfer occurs on an edge where valid & ready.
- `period_in`  in  WIDTH  requested period in clk cycles; a value below 2 is a stop command.
- `duty_in`  in  WIDTH  requested high time in clk cycles.
- `out`  out  1  generated waveform, registered.
- `rise`  out  1  one-cycle strobe, high in the first cycle of each high phase of `out`.
- `period_out`  out  WIDTH  active period, 0 when idle.
- `nosignal`  out  1  high whenever no waveform is being generated (IDLE).

## Operation
- Registers:
  - active `{P, D}`
  - pending `{Pp, Dp, pv}`
  - counter `cnt`
  - state
- Handshake:
  - `load_ready = ~pv`.
  - On an accept edge, capture into pending and set `pv = 1`.
  - Clamp at capture: if `duty_in >= period_in`, then `Dp = period_in - 1` (when `period_in >= 2`).
- IDLE:
  - `out = 0`, `nosignal = 1`, `period_out = 0`.
  - Transition: `pv & en & Pp >= 2` → RUN; load `P = Pp`, `D = Dp`, `cnt = 0`, clear `pv`.
  - `pv & Pp < 2` → consume the pending entry (clear `pv`) and stay in IDLE.
  - `pv & ~en` → hold pending and stay in IDLE.
- RUN:
  - `cnt` counts 0..P-1 and wraps to 0 (the boundary).
  - Next `out = (next cnt < D)`, registered.
  - `rise` is asserted when next `cnt == 0` and `D > 0`.
  - `D == 0` gives constant low with no `rise`.
- Boundary (`cnt == P-1`):
  - If `pv`: apply pending. Go to IDLE if `Pp < 2`, else load `P`/`D` and clear `pv`.
  - Otherwise: repeat the current period.
- `en` deasserted in RUN → DRAIN: counting continues unchanged. In DRAIN:
  - `en` reasserted before the boundary → RUN, with no phase disturbance.
  - Boundary reached with `en` still low → IDLE, `out = 0`. A pending entry is retained.
- Reset wins over everything and clears all state: `pv = 0`, state IDLE.
- Width rules:
  - `cnt` is WIDTH bits and never exceeds P-1, so it cannot overflow.
  - Maximum period is 2^WIDTH - 1.
  - Compares are unsigned.

## Timing
- Reset values: `out = 0`, `rise = 0`, `load_ready = 1`, `period_out = 0`, `nosignal = 1`.
- Start latency from IDLE with `en = 1`:
  - Accept at edge k.
  - Edge k+1 enters RUN, with `out = 1` (if `D > 0`) and `rise = 1` during cycle k+1.
  - `load_ready` returns high after edge k+1.
- In RUN, `out` is high for exactly D cycles and low for P-D cycles. Rise-to-rise spacing is exactly P cycles.
- An update accepted mid-period is applied at the next boundary. The first edge of the new period follows the last cycle of the old period with no short or long cycle.
- Accept and boundary on the same edge cannot collide: `load_ready` is low whenever `pv` is set.
- Stop command (P < 2) accepted in RUN: `out` falls to 0 after the current period completes. `nosignal` rises on the same edge.
- `rise` is never asserted while `nosignal = 1`.

## Structure
- Package `freqgen_pkg` holds:
  - state enum `{IDLE, RUN, DRAIN}`
  - `MIN_PERIOD = 2`
  - default `WIDTH = 16`
- Single module `freqgen`. No sub-module: the pending register, counter and FSM are tightly coupled.
- All outputs come straight from flops, with no combinational path from the inputs. The exception is `load_ready`, which comes directly from the `pv` flop.

## Test plan
- Reset, then load P=10, D=5 with `en=1` → `out` first high one edge after accept. Rises every 10 cycles, high for 5 cycles; `nosignal` falls to 0; `period_out = 10`.
- While running P=10, load P=4, D=1 at cycle 3 of a period → old period completes intact, then the rise spacing is 4 and the high time is 1. `load_ready` stays low until that boundary.
- Load P=6, D=9 → clamped to D=5: `out` is high 5 cycles and low 1 cycle per 6-cycle period.
- Deassert `en` mid-period → `out` finishes the period, then holds 0 with `nosignal=1`. Repeat the test with `en` reasserted before the boundary → the waveform continues without a phase change.
- Load P=0 while running → stop at the boundary with `nosignal=1`. Load P=2, D=1 → `out` alternates 1,0; `rise` fires every 2 cycles.
- Assert `rst` mid-high-phase → the next cycle shows `out=0`, `rise=0`, `load_ready=1`, `nosignal=1`, and the pending entry is discarded.
